// File: rtl/step_scheduler_if.sv
// step_scheduler_if: request/acknowledge bundle between the step scheduler
// and the move, collision-check and food units.
interface step_scheduler_if;
    logic [1:0] mv_req;
    logic       mv_ack;
    logic       chk_req;
    logic       chk_done;
    logic       hit1;
    logic       hit2;
    logic       food_req;
    logic       food_done;

    // scheduler side
    modport master (
        output mv_req, chk_req, food_req,
        input  mv_ack, chk_done, hit1, hit2, food_done
    );

    // worker-unit side
    modport slave (
        input  mv_req, chk_req, food_req,
        output mv_ack, chk_done, hit1, hit2, food_done
    );
endinterface

// File: rtl/step_scheduler.sv
// step_scheduler: sequences one game step (move snake A, move snake B,
// collision check, food check) every TICK_DIV cycles, with pause/resume,
// per-snake alive tracking and a completed-step counter.
// Optional macro STEP_TIMEOUT_EN: abort to OVER with err=1 when a request
// is not acknowledged within ACK_TMO cycles.
module step_scheduler #(
    parameter int unsigned TICK_DIV = 1250,
    parameter int unsigned ACK_TMO  = 15
) (
    input  logic             clk_raw,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    step_scheduler_if.master bus,
    output logic [2:0]       state,
    output logic [1:0]       alive,
    output logic [15:0]      steps,
    output logic             err
);

    typedef enum logic [2:0] {
        st_idle  = 3'd0,
        st_wait  = 3'd1,
        st_movea = 3'd2,
        st_moveb = 3'd3,
        st_check = 3'd4,
        st_food  = 3'd5,
        st_pause = 3'd6,
        st_over  = 3'd7
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    state_t      cur;
    state_t      nxt;
    logic [15:0] div;
    logic        first;
    logic        first_alive;
    logic        second_alive;
    logic        timeout;

    // first=0 means snake1 moves first in this step
    assign first_alive  = first ? alive[1] : alive[0];
    assign second_alive = first ? alive[0] : alive[1];

`ifdef STEP_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(ACK_TMO - 1);

    logic [15:0] tmo;
    logic        holding;
    logic        req_ack;

    assign holding = cur inside {st_movea, st_moveb, st_check, st_food};

    // acknowledge matching the request currently held
    always_comb begin
        req_ack = 1'b0;
        case (cur)
            st_movea, st_moveb: req_ack = bus.mv_ack;
            st_check:           req_ack = bus.chk_done;
            st_food:            req_ack = bus.food_done;
            default:            req_ack = 1'b0;
        endcase
    end

    // the edge that would make the count reach ACK_TMO aborts instead
    assign timeout = holding && !req_ack && (tmo == TMO_LAST);

    // per-handshake age, restarted whenever a new request is raised
    always_ff @(posedge clk_raw) begin
        if (!rst_n || !holding || nxt != cur) begin
            tmo <= '0;
        end else begin
            tmo <= tmo + 1'b1;
        end
    end

    // sticky timeout flag, cleared when leaving OVER
    always_ff @(posedge clk_raw) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end else if (cur == st_over && start) begin
            err <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // state register
    always_ff @(posedge clk_raw) begin
        if (!rst_n) begin
            cur <= st_idle;
        end else begin
            cur <= nxt;
        end
    end

    // next-state: dead snakes are skipped by routing straight past their move state
    always_comb begin
        nxt = cur;
        case (cur)
            st_idle:  if (start) nxt = st_wait;
            st_wait: begin
                if (pause && !start) begin
                    nxt = st_pause;
                end else if (div == DIV_LAST) begin
                    nxt = first_alive ? st_movea : (second_alive ? st_moveb : st_check);
                end
            end
            st_movea: if (bus.mv_ack) nxt = second_alive ? st_moveb : st_check;
            st_moveb: if (bus.mv_ack) nxt = st_check;
            st_check: if (bus.chk_done) nxt = st_food;
            st_food:  if (bus.food_done) nxt = (alive == 2'b00) ? st_over : st_wait;
            st_pause: if (start || pause) nxt = st_wait;
            st_over:  if (start) nxt = st_idle;
            default:  nxt = st_idle;
        endcase
        if (timeout) nxt = st_over;
    end

    // requests are decoded from the state, so they rise on entry and drop after the ack
    always_comb begin
        bus.mv_req   = '0;
        bus.chk_req  = 1'b0;
        bus.food_req = 1'b0;
        case (cur)
            st_movea: bus.mv_req   = first ? 2'b10 : 2'b01;
            st_moveb: bus.mv_req   = first ? 2'b01 : 2'b10;
            st_check: bus.chk_req  = 1'b1;
            st_food:  bus.food_req = 1'b1;
            default:  ;
        endcase
    end

    // game bookkeeping: alive flags, step count, move order, WAIT divider
    always_ff @(posedge clk_raw) begin
        if (!rst_n) begin
            alive <= '0;
            steps <= '0;
            first <= 1'b0;
            div   <= '0;
        end else begin
            if (cur == st_idle && start) begin
                alive <= 2'b11;
                steps <= '0;
                first <= 1'b0;
            end
            if (cur == st_check && bus.chk_done) begin
                alive <= alive & ~{bus.hit2, bus.hit1};
            end
            if (cur == st_food && bus.food_done) begin
                steps <= steps + 1'b1;
                first <= ~first;
            end
            // divider freezes on pause and is kept on resume from PAUSE
            if (cur == st_wait && nxt == st_wait) begin
                div <= div + 1'b1;
            end else if (nxt == st_wait && cur != st_wait && cur != st_pause) begin
                div <= '0;
            end
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler: directed stimulus with an auto-responding worker model,
// a step-plan reference model compared every cycle, and literal spot checks.
module tb_step_scheduler;

    localparam int TICK = 4;
    localparam int TMO  = 5;

    localparam int K_MOVE  = 0;
    localparam int K_CHECK = 1;
    localparam int K_FOOD  = 2;

    logic        clk_raw = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        pause   = 1'b0;
    logic [2:0]  state;
    logic [1:0]  alive;
    logic [15:0] steps;
    logic        err;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    step_scheduler_if bus();

    step_scheduler #(.TICK_DIV(TICK), .ACK_TMO(TMO)) dut (
        .clk_raw (clk_raw),
        .rst_n   (rst_n),
        .start   (start),
        .pause   (pause),
        .bus     (bus.master),
        .state   (state),
        .alive   (alive),
        .steps   (steps),
        .err     (err)
    );

    always #5 clk_raw = ~clk_raw;

    // ---------------- worker responder ----------------
    bit         en_mv = 1'b1, en_chk = 1'b1, en_food = 1'b1;
    bit         m_chk = 1'b0;
    bit         hit1_v = 1'b0, hit2_v = 1'b0;
    logic       r_mv = 1'b0, r_chk = 1'b0, r_food = 1'b0;
    logic [1:0] prev_mv = 2'b00;
    logic       prev_chk = 1'b0, prev_food = 1'b0;
    int         mv_cnt = 0, chk_cnt = 0, food_cnt = 0;

    assign bus.mv_ack    = r_mv;
    assign bus.chk_done  = r_chk | m_chk;
    assign bus.food_done = r_food;
    assign bus.hit1      = hit1_v;
    assign bus.hit2      = hit2_v;

    // acknowledge one cycle after a request is first seen
    initial forever begin
        @(negedge clk_raw);
        if (bus.mv_req != 2'b00 && bus.mv_req == prev_mv) mv_cnt++; else mv_cnt = 0;
        prev_mv = bus.mv_req;
        r_mv = en_mv && (bus.mv_req != 2'b00) && (mv_cnt >= 1);
        if (bus.chk_req === 1'b1 && prev_chk) chk_cnt++; else chk_cnt = 0;
        prev_chk = (bus.chk_req === 1'b1);
        r_chk = en_chk && prev_chk && (chk_cnt >= 1);
        if (bus.food_req === 1'b1 && prev_food) food_cnt++; else food_cnt = 0;
        prev_food = (bus.food_req === 1'b1);
        r_food = en_food && prev_food && (food_cnt >= 1);
    end

    // ---------------- reference model ----------------
    typedef struct {
        int kind;
        int slot;
        int snake;
    } item_t;

    item_t       plan[$];
    bit          m_idle, m_over, m_paused, m_first, m_err;
    bit   [1:0]  m_alive;
    bit   [15:0] m_steps;
    int          m_elapsed, m_held;

    task automatic model_step();
        item_t h;
        bit    done;
        int    order[2];
        if (!rst_n) begin
            m_idle = 1; m_over = 0; m_paused = 0; plan.delete();
            m_alive = 0; m_steps = 0; m_err = 0; m_first = 0;
            m_elapsed = 0; m_held = 0;
            return;
        end
        if (m_idle) begin
            if (start) begin
                m_idle = 0; m_alive = 2'b11; m_steps = 0; m_first = 0; m_elapsed = 0;
            end
        end else if (m_over) begin
            if (start) begin
                m_over = 0; m_idle = 1; m_err = 0;
            end
        end else if (m_paused) begin
            if (start || pause) m_paused = 0;
        end else if (plan.size() == 0) begin
            if (pause && !start) begin
                m_paused = 1;
            end else if (m_elapsed == TICK - 1) begin
                order[0] = m_first ? 2 : 1;
                order[1] = m_first ? 1 : 2;
                for (int s = 0; s < 2; s++) begin
                    if (m_alive[order[s] - 1]) plan.push_back('{K_MOVE, s, order[s]});
                end
                plan.push_back('{K_CHECK, 0, 0});
                plan.push_back('{K_FOOD, 0, 0});
                m_held = 0;
            end else begin
                m_elapsed++;
            end
        end else begin
            h = plan[0];
            if (h.kind == K_MOVE)       done = bus.mv_ack;
            else if (h.kind == K_CHECK) done = bus.chk_done;
            else                        done = bus.food_done;
            if (done) begin
                if (h.kind == K_CHECK) m_alive = m_alive & ~{bus.hit2, bus.hit1};
                if (h.kind == K_FOOD) begin
                    m_steps++;
                    m_first = !m_first;
                    m_elapsed = 0;
                    if (m_alive == 2'b00) m_over = 1;
                end
                void'(plan.pop_front());
                m_held = 0;
            end else begin
                m_held++;
`ifdef STEP_TIMEOUT_EN
                if (m_held == TMO) begin
                    plan.delete(); m_over = 1; m_err = 1;
                end
`endif
            end
        end
    endtask

    initial forever begin
        @(posedge clk_raw);
        model_step();
    end

    function automatic logic [2:0] exp_state();
        if (m_idle) return 3'd0;
        if (m_over) return 3'd7;
        if (m_paused) return 3'd6;
        if (plan.size() == 0) return 3'd1;
        if (plan[0].kind == K_MOVE) return (plan[0].slot == 0) ? 3'd2 : 3'd3;
        if (plan[0].kind == K_CHECK) return 3'd4;
        return 3'd5;
    endfunction

    function automatic logic [1:0] exp_mv();
        if (m_idle || m_over || m_paused || plan.size() == 0) return 2'b00;
        if (plan[0].kind != K_MOVE) return 2'b00;
        return (plan[0].snake == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic exp_kind(input int k);
        if (m_idle || m_over || m_paused || plan.size() == 0) return 1'b0;
        return plan[0].kind == k;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    initial forever begin
        @(negedge clk_raw);
        if (cmp_en) begin
            chk("state", 32'(state), 32'(exp_state()));
            chk("mv_req", 32'(bus.mv_req), 32'(exp_mv()));
            chk("chk_req", 32'(bus.chk_req), 32'(exp_kind(K_CHECK)));
            chk("food_req", 32'(bus.food_req), 32'(exp_kind(K_FOOD)));
            chk("alive", 32'(alive), 32'(m_alive));
            chk("steps", 32'(steps), 32'(m_steps));
            chk("err", 32'(err), 32'(m_err));
            chk("one_req", 32'(((bus.mv_req != 2'b00) ? 1 : 0) + (bus.chk_req ? 1 : 0)
                               + (bus.food_req ? 1 : 0) <= 1), 32'd1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_raw);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        @(negedge clk_raw);
        pause = 1'b0;
    endtask

    task automatic wait_mv(output logic [1:0] v);
        int n = 0;
        while (bus.mv_req == 2'b00 && n < 40) begin
            @(negedge clk_raw);
            n++;
        end
        if (bus.mv_req == 2'b00) begin
            checks++; errors++;
            $display("FAIL wait_mv actual=timeout required=mv_req at %0t", $time);
        end
        v = bus.mv_req;
    endtask

    task automatic wait_steps(input logic [15:0] n_req);
        int n = 0;
        while (steps != n_req && n < 60) begin
            @(negedge clk_raw);
            n++;
        end
        chk("wait_steps", 32'(steps), 32'(n_req));
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (state != s && n < 60) begin
            @(negedge clk_raw);
            n++;
        end
        chk("wait_state", 32'(state), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0] v;
        @(negedge clk_raw);
        cmp_en = 1'b1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_alive", 32'(alive), 32'd0);
        chk("rst_steps", 32'(steps), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mv", 32'(bus.mv_req), 32'd0);
        @(negedge clk_raw);
        rst_n = 1'b1;
        @(negedge clk_raw);

        // game 1, step 1: normal order snake1 then snake2
        pulse_start();
        chk("started_wait", 32'(state), 32'd1);
        wait_mv(v);
        chk("step1_first_mv", 32'(v), 32'h1);
        wait_steps(16'd1);
        chk("step1_alive", 32'(alive), 32'h3);
        chk("step1_back_wait", 32'(state), 32'd1);

        // start and pause together in WAIT: pause is dropped
        start = 1'b1; pause = 1'b1;
        @(negedge clk_raw);
        start = 1'b0; pause = 1'b0;
        chk("start_over_pause", 32'(state), 32'd1);

        // step 2: order flipped, snake1 collides
        wait_mv(v);
        chk("step2_first_mv", 32'(v), 32'h2);
        hit1_v = 1'b1;
        wait_steps(16'd2);
        hit1_v = 1'b0;
        chk("step2_alive", 32'(alive), 32'h2);

        // step 3: snake1 dead, MOVEA skipped; pause mid-step dropped; snake2 dies
        wait_mv(v);
        chk("step3_mv", 32'(v), 32'h2);
        chk("step3_skip_movea", 32'(state), 32'd3);
        pulse_pause();
        hit2_v = 1'b1;
        wait_steps(16'd3);
        hit2_v = 1'b0;
        chk("step3_alive", 32'(alive), 32'h0);
        chk("step3_over", 32'(state), 32'd7);
        repeat (3) @(negedge clk_raw);
        pulse_start();
        chk("over_to_idle", 32'(state), 32'd0);

        // game 2: pause at divider=2, resume after 100 cycles
        pulse_start();
        @(negedge clk_raw);
        @(negedge clk_raw);
        pulse_pause();
        chk("paused", 32'(state), 32'd6);
        repeat (100) @(negedge clk_raw);
        chk("still_paused", 32'(state), 32'd6);
        pulse_start();
        chk("resume_wait0", 32'(state), 32'd1);
        @(negedge clk_raw);
        chk("resume_wait1", 32'(state), 32'd1);
        @(negedge clk_raw);
        chk("resume_movea", 32'(state), 32'd2);

        // both snakes die in the same check
        hit1_v = 1'b1; hit2_v = 1'b1;
        wait_steps(16'd1);
        hit1_v = 1'b0; hit2_v = 1'b0;
        chk("both_dead_alive", 32'(alive), 32'h0);
        chk("both_dead_over", 32'(state), 32'd7);
        pulse_start();
        chk("g2_idle", 32'(state), 32'd0);

        // game 3: withheld move ack
        pulse_start();
        en_mv = 1'b0;
        wait_mv(v);
        chk("tmo_mv", 32'(v), 32'h1);
`ifdef STEP_TIMEOUT_EN
        repeat (TMO - 1) @(negedge clk_raw);
        chk("tmo_not_yet", 32'(state), 32'd2);
        @(negedge clk_raw);
        chk("tmo_over", 32'(state), 32'd7);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_mv_drop", 32'(bus.mv_req), 32'd0);
        en_mv = 1'b1;
        pulse_start();
        chk("tmo_err_clr", 32'(err), 32'd0);
        pulse_start();
`else
        repeat (3 * TMO) @(negedge clk_raw);
        chk("no_tmo_mv", 32'(bus.mv_req), 32'h1);
        chk("no_tmo_err", 32'(err), 32'd0);
        en_mv = 1'b1;
`endif

        // reset while a collision check is outstanding, then a late chk_done
        en_chk = 1'b0;
        wait_state(3'd4);
        repeat (2) @(negedge clk_raw);
        chk("pre_rst_chk_req", 32'(bus.chk_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk_raw);
        rst_n = 1'b1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_chk_req", 32'(bus.chk_req), 32'd0);
        chk("mid_rst_alive", 32'(alive), 32'd0);
        chk("mid_rst_steps", 32'(steps), 32'd0);
        m_chk = 1'b1; hit1_v = 1'b1;
        @(negedge clk_raw);
        m_chk = 1'b0; hit1_v = 1'b0;
        chk("late_done_state", 32'(state), 32'd0);
        chk("late_done_alive", 32'(alive), 32'd0);
        en_chk = 1'b1;
        repeat (3) @(negedge clk_raw);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
